mem_arbiter: RTL
================

# mem_arbiter

- Two-requester arbiter sharing the single-port accelerator memory between the host AXI slave port (requester A) and the local compute core (requester B).
- Drives the memory's mem_we / mem_addr / mem_wdata interface and routes mem_rdata back to whichever requester issued each read.
- Uses registered round-robin grants, a per-grant access quota to bound starvation, and a lock input for atomic bursts.
- Read returns are tracked through a latency pipeline, so a read that is still in flight when the grant switches returns to its issuer.

## Interface
Parameters:
- DWIDTH, 32, data width
- MEMSIZE, 10, word-address width
- RD_LAT, 1, memory read latency in cycles, legal 1..4
- MAX_HOLD, 16, accesses granted per turn while the other side waits, legal 1..255

Ports (clock and reset first; one clock; reset is synchronous and active-low):
- clk  in  1  clock
- xrst  in  1  synchronous active-low reset
- a_req  in  1  A requests an access this cycle
- a_lock  in  1  A forbids quota preemption while high
- a_we  in  1  A access is a write
- a_addr  in  MEMSIZE  A word address
- a_wdata  in  DWIDTH  A write data
- a_gnt  out  1  A owns the memory
- a_rvalid  out  1  A read data valid
- a_rdata  out  DWIDTH  A read data
- b_req, b_lock, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for B
- mem_we  out  1  memory write enable
- mem_addr  out  MEMSIZE  memory address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data, valid RD_LAT cycles after the address
- owner  out  2  01 = A, 10 = B, 00 = idle

## Operation
FSM states: IDLE, GNT_A, GNT_B. a_gnt, b_gnt and owner decode the state register.

Access rule:
- An access is accepted in any cycle where x_gnt && x_req.
- An accepted access with x_we = 1 is a write; with x_we = 0 it is a read.

Memory mux (combinational from state):
- mem_addr = owner's addr; 0 when IDLE.
- mem_wdata = owner's wdata; 0 when IDLE.
- mem_we = x_gnt && x_req && x_we.

Transitions, evaluated every cycle:
- IDLE:
  - a_req && b_req: grant the side not in last_owner.
  - Otherwise grant the requesting side.
  - No request: stay in IDLE.
- GNT_A:
  - !a_req: go to GNT_B if b_req, else IDLE.
  - a_req && b_req && !a_lock && hold_cnt == MAX_HOLD-1 && access accepted this cycle: go to GNT_B.
  - Otherwise stay in GNT_A.
- GNT_B: symmetric to GNT_A.

last_owner:
- Updated to the departing owner on every exit from GNT_A or GNT_B.
- Reset value B, so A wins the first tie.

hold_cnt (8-bit):
- Cleared on every state change.
- Increments on each accepted access while the other side's req is high.
- Holds otherwise; saturates at MAX_HOLD-1.
- A lone requester therefore keeps its grant indefinitely.
- With both sides requesting and no lock, each turn is exactly MAX_HOLD accesses.
- Lock only blocks quota preemption. Dropping req always releases the grant, even with lock high.

Read return:
- RD_LAT-deep shift register of {valid, tag}; tag = 0 for A, 1 for B.
- An entry is pushed for every accepted read.
- x_rvalid = pipe valid && tag matches x, at depth RD_LAT.
- a_rdata = b_rdata = mem_rdata (unqualified; consumers gate with rvalid).
- In-flight reads complete to their issuer regardless of later grant changes.

Writes have no response; the write takes effect in the accept cycle.

## Timing
Reset values, held for the full reset cycle:
- State IDLE, owner 00, a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0.
- hold_cnt 0, read pipe cleared, last_owner B.
- mem_we = 0, mem_addr = 0, mem_wdata = 0.

Latencies:
- Request-to-grant: x_req high in cycle t while IDLE gives x_gnt = 1 at t+1; first access at t+1.
- Switch: the new owner's grant appears the cycle after the switch condition. There is no idle bubble between owners when the other side is waiting.
- Read: accepted at t gives x_rvalid at t+RD_LAT for exactly one cycle. Back-to-back reads give back-to-back rvalid.

Grant:
- Never both high.
- Changes only on a clock edge.

Reset mid-operation:
- Pending read returns are discarded; no rvalid follows reset.
- The grant drops in the cycle after xrst is sampled low.

Simultaneous events:
- Owner drops req in the cycle the quota expires: the !req branch governs, and the result is the same as a quota switch.
- Lock rising in the quota-expiry cycle suppresses the switch.

## Test plan
- Reset, then a_req only: a_gnt = 1 one cycle later. Writes to 0x005 / 0x006 drive mem_we = 1 with the matching address. A read of 0x005 gives a_rvalid at +RD_LAT with a_rdata = value written. owner = 01 throughout the grant.
- a_req and b_req asserted together from IDLE after reset: A granted first. With MAX_HOLD = 4, continuous requests alternate exactly 4 A accesses, 4 B accesses, repeated, with no idle cycle between turns.
- A holds a_lock = 1 for a 10-access burst while b_req stays high: A keeps the grant for all 10 accesses. b_gnt rises the cycle after A drops a_req.
- A issues a read at the cycle its quota expires; RD_LAT = 3: a_rvalid asserts 3 cycles later while b_gnt = 1. b_rvalid does not assert for that read.
- xrst pulsed low for one cycle during B's read burst: no rvalid afterwards, owner = 00, all memory outputs 0. b_req still high gives b_gnt = 1 one cycle after reset deasserts.
- Single-requester stress, B requests for 300 cycles with MAX_HOLD = 16: b_gnt never drops and hold_cnt never causes a switch.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between requester A (host AXI
// slave) and requester B (compute core) using registered round-robin grants,
// a per-turn access quota and a lock for atomic bursts.
//
// Ports:
//   clk, xrst                      clock, synchronous active-low reset
//   a_req/a_lock/a_we/a_addr/a_wdata   A request, lock and access payload
//   a_gnt, a_rvalid, a_rdata       A grant and read return
//   b_*                            same as A, for B
//   mem_we, mem_addr, mem_wdata    memory access (muxed from the owner)
//   mem_rdata                      memory read data, RD_LAT cycles after address
//   owner                          01 = A, 10 = B, 00 = idle
module mem_arbiter #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned MEMSIZE  = 10,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               a_req,
  input  logic               a_lock,
  input  logic               a_we,
  input  logic [MEMSIZE-1:0] a_addr,
  input  logic [DWIDTH-1:0]  a_wdata,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [DWIDTH-1:0]  a_rdata,
  input  logic               b_req,
  input  logic               b_lock,
  input  logic               b_we,
  input  logic [MEMSIZE-1:0] b_addr,
  input  logic [DWIDTH-1:0]  b_wdata,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [DWIDTH-1:0]  b_rdata,
  output logic               mem_we,
  output logic [MEMSIZE-1:0] mem_addr,
  output logic [DWIDTH-1:0]  mem_wdata,
  input  logic [DWIDTH-1:0]  mem_rdata,
  output logic [1:0]         owner
);

  localparam int unsigned HOLD_W    = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  // Encoding doubles as the owner code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                last_b_q, last_b_d;   // 1: B owned last
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]   pipe_tag_q, pipe_tag_d;

  logic a_acc, b_acc, rd_push;

  assign a_gnt = (state_q == GNT_A);
  assign b_gnt = (state_q == GNT_B);
  assign owner = state_q;

  assign a_acc   = a_gnt && a_req;
  assign b_acc   = b_gnt && b_req;
  assign rd_push = (a_acc && !a_we) || (b_acc && !b_we);

  // Memory mux from the current owner.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      GNT_A: begin
        mem_we    = a_req && a_we;
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
      end
      GNT_B: begin
        mem_we    = b_req && b_we;
        mem_addr  = b_addr;
        mem_wdata = b_wdata;
      end
      default: ;
    endcase
  end

  // Next-state, last owner and quota counter.
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        if (a_req && b_req)  state_d = last_b_q ? GNT_A : GNT_B;
        else if (a_req)      state_d = GNT_A;
        else if (b_req)      state_d = GNT_B;
      end
      GNT_A: begin
        if (!a_req)          state_d = b_req ? GNT_B : IDLE;
        else if (b_req && !a_lock && (hold_q == HOLD_LAST))
                             state_d = GNT_B;
      end
      GNT_B: begin
        if (!b_req)          state_d = a_req ? GNT_A : IDLE;
        else if (a_req && !b_lock && (hold_q == HOLD_LAST))
                             state_d = GNT_A;
      end
      default:               state_d = IDLE;
    endcase

    if ((state_q == GNT_A) && (state_d != GNT_A)) last_b_d = 1'b0;
    if ((state_q == GNT_B) && (state_d != GNT_B)) last_b_d = 1'b1;

    // Only accesses made while the other side waits count toward the quota.
    if (state_d != state_q) begin
      hold_d = '0;
    end else if (((a_acc && b_req) || (b_acc && a_req)) && (hold_q != HOLD_LAST)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Read-return pipe: {valid, tag}, tag 1 = B.
  always_comb begin
    pipe_vld_d = RD_LAT'({pipe_vld_q, rd_push});
    pipe_tag_d = RD_LAT'({pipe_tag_q, b_acc});
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      hold_q     <= '0;
      pipe_vld_q <= '0;
      pipe_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      hold_q     <= hold_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

  assign a_rvalid = pipe_vld_q[RD_LAT-1] && !pipe_tag_q[RD_LAT-1];
  assign b_rvalid = pipe_vld_q[RD_LAT-1] &&  pipe_tag_q[RD_LAT-1];
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule
